// File: rtl/seg7_pkg.sv
// Shared types and default 50 MHz timing constants for the 7-segment counter
// front end; imported by the button conditioner and by the counter top.
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    localparam int DEBOUNCE_CYCLES_DEFAULT      = 50_000;      // 1 ms
    localparam int REPEAT_DELAY_CYCLES_DEFAULT  = 25_000_000;  // 500 ms
    localparam int REPEAT_PERIOD_CYCLES_DEFAULT = 5_000_000;   // 100 ms

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; synchronous
// active-high reset clears both stages to 0.
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic meta;

    // NOTE: non-blocking assignments make meta and o_q two distinct flops; blocking would collapse the chain.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            meta <= 1'b0;
            o_q  <= 1'b0;
        end else begin
            meta <= i_d;
            o_q  <= meta;
        end
    end

endmodule

// File: rtl/button_click_debouncer.sv
// Raw push-button -> synchronized, debounced level plus a one-cycle click pulse.
// Define AUTO_REPEAT_EN to add timed auto-repeat clicks while the button is held.
module button_click_debouncer
    import seg7_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES      = DEBOUNCE_CYCLES_DEFAULT,
    parameter int REPEAT_DELAY_CYCLES  = REPEAT_DELAY_CYCLES_DEFAULT,
    parameter int REPEAT_PERIOD_CYCLES = REPEAT_PERIOD_CYCLES_DEFAULT
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_button,
    output logic o_click,
    output logic o_pressed
);

    localparam int CNT_W = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY_CYCLES,
                                       REPEAT_PERIOD_CYCLES)) + 1;

    // Debounce waits are DEBOUNCE_CYCLES stable cycles after the entry cycle.
    localparam logic [CNT_W-1:0] DEBOUNCE_LAST = CNT_W'(DEBOUNCE_CYCLES);

    logic             button_sync;
    btn_state_t       state;
    logic [CNT_W-1:0] db_cnt;
    logic             rep_fire;

    sync_2ff u_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_button),
        .o_q   (button_sync)
    );

`ifdef AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_DELAY_LAST  = CNT_W'(REPEAT_DELAY_CYCLES);
    localparam logic [CNT_W-1:0] REPEAT_PERIOD_LAST = CNT_W'(REPEAT_PERIOD_CYCLES - 1);

    logic [CNT_W-1:0] rep_cnt;
    logic             rep_first;

    // First repeat waits the long delay, later ones the short period.
    assign rep_fire = (state == HELD) && button_sync &&
                      (rep_cnt == (rep_first ? REPEAT_DELAY_LAST : REPEAT_PERIOD_LAST));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rep_cnt   <= '0;
            rep_first <= 1'b1;
        end else if (state == HELD && button_sync) begin
            if (rep_fire) begin
                rep_cnt   <= '0;
                rep_first <= 1'b0;
            end else begin
                rep_cnt <= rep_cnt + 1'b1;
            end
        end else begin
            // Any time outside a steady HELD re-arms the full initial delay.
            rep_cnt   <= '0;
            rep_first <= 1'b1;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            db_cnt    <= '0;
            o_click   <= 1'b0;
            o_pressed <= 1'b0;
        end else begin
            // NOTE: o_click defaults low every cycle so each raise below is a single-cycle pulse.
            o_click <= 1'b0;
            case (state)
                IDLE: begin
                    if (button_sync) begin
                        state  <= PRESS_WAIT;
                        db_cnt <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!button_sync) begin
                        state <= IDLE;
                    end else if (db_cnt == DEBOUNCE_LAST) begin
                        state     <= HELD;
                        o_click   <= 1'b1;
                        o_pressed <= 1'b1;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!button_sync) begin
                        state  <= RELEASE_WAIT;
                        db_cnt <= '0;
                    end else if (rep_fire) begin
                        o_click <= 1'b1;
                    end
                end
                RELEASE_WAIT: begin
                    if (button_sync) begin
                        state <= HELD;
                    end else if (db_cnt == DEBOUNCE_LAST) begin
                        state     <= IDLE;
                        o_pressed <= 1'b0;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_button_click_debouncer.sv
// Self-checking bench for button_click_debouncer: segment table with a
// click/level scoreboard, plus exact-latency and reset-abort sequences.
module tb_button_click_debouncer;

    localparam int DEB = 4;
    localparam int LAT = 7;   // press/release: output changes after edge E0+3+DEB

`ifdef AUTO_REPEAT_EN
    localparam int REP = 1;
`else
    localparam int REP = 0;
`endif

    typedef struct {
        logic rst;
        logic btn;
        int   len;
        int   exp_clicks;
        logic exp_pressed;
    } seg_t;

    typedef struct {
        int   clicks;
        logic pressed;
    } sb_t;

    logic i_clk;
    logic i_rst;
    logic i_button;
    logic o_click;
    logic o_pressed;

    int   n_checks = 0;
    int   n_errors = 0;
    logic prev_click = 1'b0;
    sb_t  sb_q[$];
    seg_t segs[12];

    button_click_debouncer #(
        .DEBOUNCE_CYCLES      (DEB),
        .REPEAT_DELAY_CYCLES  (10),
        .REPEAT_PERIOD_CYCLES (3)
    ) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_button  (i_button),
        .o_click   (o_click),
        .o_pressed (o_pressed)
    );

    initial i_clk = 1'b0;
    always #1 i_clk = ~i_clk;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // One clock edge: drive inputs, let the edge sample them, observe on the falling edge.
    task automatic tick(input logic rst, input logic btn);
        i_rst    = rst;
        i_button = btn;
        @(posedge i_clk);
        @(negedge i_clk);
        if (o_click) check("click_not_back_to_back", int'(prev_click), 0);
        prev_click = o_click;
        if (rst) begin
            check("reset_click", int'(o_click), 0);
            check("reset_pressed", int'(o_pressed), 0);
        end
    endtask

    initial begin
        sb_t exp;
        int  clicks;

        //            rst   btn   len  clicks      pressed
        segs[0]  = '{1'b1, 1'b1, 2,  0,          1'b0};  // reset with button held
        segs[1]  = '{1'b0, 1'b0, 6,  0,          1'b0};
        segs[2]  = '{1'b0, 1'b1, 20, 1 + REP,    1'b1};  // clean press
        segs[3]  = '{1'b0, 1'b0, 20, REP,        1'b0};  // clean release
        segs[4]  = '{1'b0, 1'b1, 3,  0,          1'b0};  // 3-cycle glitch
        segs[5]  = '{1'b0, 1'b0, 10, 0,          1'b0};
        segs[6]  = '{1'b0, 1'b1, 12, 1,          1'b1};  // press
        segs[7]  = '{1'b0, 1'b0, 2,  0,          1'b1};  // release bounce
        segs[8]  = '{1'b0, 1'b1, 6,  0,          1'b1};
        segs[9]  = '{1'b0, 1'b0, 12, 0,          1'b0};
        segs[10] = '{1'b0, 1'b1, 40, 1 + 8 * REP, 1'b1}; // long hold
        segs[11] = '{1'b0, 1'b0, 12, 0,          1'b0};

        for (int i = 0; i < 12; i++) begin
            sb_q.push_back('{clicks: segs[i].exp_clicks, pressed: segs[i].exp_pressed});
            clicks = 0;
            for (int c = 0; c < segs[i].len; c++) begin
                tick(segs[i].rst, segs[i].btn);
                clicks += int'(o_click);
            end
            exp = sb_q.pop_front();
            check($sformatf("seg%0d_clicks", i), clicks, exp.clicks);
            check($sformatf("seg%0d_pressed", i), int'(o_pressed), int'(exp.pressed));
        end

        // Exact press latency: pulse and level rise together after edge E0+7.
        for (int k = 0; k < 10; k++) begin
            tick(1'b0, 1'b1);
            check($sformatf("lat_press_click_e%0d", k), int'(o_click), int'(k == LAT));
            check($sformatf("lat_press_level_e%0d", k), int'(o_pressed), int'(k >= LAT));
        end
        // Exact release latency: level falls after edge R0+7, no pulse.
        for (int k = 0; k < 10; k++) begin
            tick(1'b0, 1'b0);
            check($sformatf("lat_rel_click_e%0d", k), int'(o_click), 0);
            check($sformatf("lat_rel_level_e%0d", k), int'(o_pressed), int'(k < LAT));
        end

        // Reset mid-press: abort at E0+4, then a full-latency press after reset.
        for (int k = 0; k < 4; k++) begin
            tick(1'b0, 1'b1);
            check($sformatf("pre_rst_click_e%0d", k), int'(o_click), 0);
        end
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        for (int k = 0; k < 10; k++) begin
            tick(1'b0, 1'b1);
            check($sformatf("post_rst_click_e%0d", k), int'(o_click), int'(k == LAT));
            check($sformatf("post_rst_level_e%0d", k), int'(o_pressed), int'(k >= LAT));
        end
        for (int k = 0; k < 12; k++) tick(1'b0, 1'b0);
        check("post_rst_release_level", int'(o_pressed), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no end of test, expected end before t=20000");
        $fatal(1, "timeout");
    end

endmodule
